// File: rtl/keypad_event_ahb_pkg.sv
// Shared constants for the keypad event capture block: register offsets,
// register bit positions and FIFO entry geometry.
package keypad_event_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_CMD    = 2'd3
    } reg_sel_e;

    localparam int CTRL_EN_BIT     = 0;
    localparam int CTRL_IRQEN_BIT  = 1;
    localparam int CMD_FLUSH_BIT   = 0;
    localparam int CMD_CLR_OVF_BIT = 1;

    localparam int STAT_EMPTY_BIT  = 4;
    localparam int STAT_FULL_BIT   = 5;
    localparam int STAT_OVF_BIT    = 6;

    localparam int MASK_WIDTH          = 4;
    localparam int DEFAULT_FIFO_DEPTH  = 8;
    localparam int DEFAULT_TS_WIDTH    = 16;
    localparam int DEFAULT_ENTRY_WIDTH = DEFAULT_TS_WIDTH + MASK_WIDTH;

    // Entry layout is {timestamp, column mask}
    function automatic int entry_width(input int ts_width);
        return ts_width + MASK_WIDTH;
    endfunction

endpackage

// File: rtl/keypad_event_ahb_if.sv
// AHB-Lite bus bundle between the Cortex-M0 interconnect and the keypad
// event slave.
interface keypad_event_ahb_if;
    logic        HSEL;
    logic [3:0]  HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic [31:0] HRDATA;
    logic        HREADYOUT;
    logic        HRESP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HRDATA, HREADYOUT, HRESP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HRDATA, HREADYOUT, HRESP
    );
endinterface

// File: rtl/keypad_event_ahb_fifo.sv
// Synchronous event FIFO with flush. Head data is read asynchronously so a
// DATA read can return the head in the same cycle it is popped.
module keypad_evt_fifo #(
    parameter int WIDTH = 20,
    parameter int DEPTH = 8,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);
    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_reg [DEPTH];
    logic [PTR_W-1:0] wr_ptr_reg;
    logic [PTR_W-1:0] rd_ptr_reg;
    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             do_push;
    logic             do_pop;

    assign empty = (count_reg == '0);
    assign full  = (count_reg == CNT_W'(DEPTH));
    assign count = count_reg;
    assign dout  = mem_reg[rd_ptr_reg];

    // Flush dominates; a push into a full FIFO is accepted only when a pop
    // frees the slot in the same cycle.
    assign do_pop  = pop & ~empty & ~flush;
    assign do_push = push & ~flush & (~full | do_pop);

    always_comb begin
        count_next = count_reg;
        unique case ({do_push, do_pop})
            2'b10:   count_next = count_reg + 1'b1;
            2'b01:   count_next = count_reg - 1'b1;
            default: count_next = count_reg;
        endcase
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_reg[wr_ptr_reg] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (srst || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/keypad_event_ahb.sv
// AHB-Lite slave that timestamps keypad debouncer pulses into an event FIFO
// and exposes DATA/STATUS/CTRL/CMD registers plus a level interrupt.
module keypad_event_ahb
    import keypad_event_pkg::*;
#(
    parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH,
    parameter int TS_WIDTH   = DEFAULT_TS_WIDTH
) (
    input  logic                     HCLK,
    input  logic                     HRESET,
    keypad_event_ahb_if.slave        bus,
    input  logic [MASK_WIDTH-1:0]    key_interrupt,
    output logic                     key_irq
);
    localparam int ENTRY_W = entry_width(TS_WIDTH);
    localparam int CNT_W   = $clog2(FIFO_DEPTH) + 1;

    logic                  addr_valid_reg;
    logic                  addr_write_reg;
    reg_sel_e              addr_sel_reg;

    logic [1:0]            ctrl_reg;
    logic [TS_WIDTH-1:0]   ts_reg;
    logic                  ovf_reg;
    logic                  ovf_next;

    logic                  rd_phase;
    logic                  wr_phase;
    logic                  pop_req;
    logic                  push_req;
    logic                  flush_cmd;
    logic                  clr_ovf_cmd;
    logic                  ctrl_we;
    logic                  en;
    logic                  irqen;

    logic [ENTRY_W-1:0]    fifo_din;
    logic [ENTRY_W-1:0]    fifo_dout;
    logic [CNT_W-1:0]      fifo_count;
    logic                  fifo_full;
    logic                  fifo_empty;

    logic [31:0]           rdata;
    logic                  unused_bus_bits;

    assign unused_bus_bits = ^{bus.HSIZE, bus.HADDR[1:0], bus.HTRANS[0], bus.HWDATA[31:2]};

    assign en    = ctrl_reg[CTRL_EN_BIT];
    assign irqen = ctrl_reg[CTRL_IRQEN_BIT];

    // Address phase register; the following cycle is the data phase.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            addr_valid_reg <= 1'b0;
            addr_write_reg <= 1'b0;
            addr_sel_reg   <= REG_DATA;
        end else begin
            addr_valid_reg <= bus.HSEL & bus.HTRANS[1] & bus.HREADY;
            if (bus.HSEL & bus.HTRANS[1] & bus.HREADY) begin
                addr_write_reg <= bus.HWRITE;
                addr_sel_reg   <= reg_sel_e'(bus.HADDR[3:2]);
            end
        end
    end

    assign rd_phase    = addr_valid_reg & ~addr_write_reg;
    assign wr_phase    = addr_valid_reg &  addr_write_reg;
    assign pop_req     = rd_phase & (addr_sel_reg == REG_DATA);
    assign ctrl_we     = wr_phase & (addr_sel_reg == REG_CTRL);
    assign flush_cmd   = wr_phase & (addr_sel_reg == REG_CMD) & bus.HWDATA[CMD_FLUSH_BIT];
    assign clr_ovf_cmd = wr_phase & (addr_sel_reg == REG_CMD) & bus.HWDATA[CMD_CLR_OVF_BIT];
    assign push_req    = en & (|key_interrupt);
    assign fifo_din    = {ts_reg, key_interrupt};

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ctrl_reg <= '0;
        end else if (ctrl_we) begin
            ctrl_reg <= bus.HWDATA[1:0];
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ts_reg <= '0;
        end else if (en) begin
            ts_reg <= ts_reg + 1'b1;
        end
    end

    // A dropped event (full, no pop, no flush) sets overflow; setting beats
    // a simultaneous CLR_OVF.
    always_comb begin
        ovf_next = ovf_reg;
        if (push_req & ~flush_cmd & fifo_full & ~pop_req) begin
            ovf_next = 1'b1;
        end else if (clr_ovf_cmd) begin
            ovf_next = 1'b0;
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            ovf_reg <= 1'b0;
        end else begin
            ovf_reg <= ovf_next;
        end
    end

    keypad_evt_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk   (HCLK),
        .srst  (HRESET),
        .push  (push_req),
        .pop   (pop_req),
        .flush (flush_cmd),
        .din   (fifo_din),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        rdata = '0;
        if (rd_phase) begin
            unique case (addr_sel_reg)
                REG_DATA: begin
                    if (!fifo_empty) begin
                        rdata = {16'(fifo_dout[ENTRY_W-1:MASK_WIDTH]), 12'h000,
                                 fifo_dout[MASK_WIDTH-1:0]};
                    end
                end
                REG_STATUS: begin
                    rdata[3:0]            = 4'(fifo_count);
                    rdata[STAT_EMPTY_BIT] = fifo_empty;
                    rdata[STAT_FULL_BIT]  = fifo_full;
                    rdata[STAT_OVF_BIT]   = ovf_reg;
                end
                REG_CTRL: rdata[1:0] = ctrl_reg;
                default:  rdata = '0;
            endcase
        end
    end

    assign bus.HRDATA    = rdata;
    assign bus.HREADYOUT = 1'b1;
    assign bus.HRESP     = 1'b0;
    assign key_irq       = en & irqen & ~fifo_empty;

endmodule

// File: tb/tb_keypad_event_ahb.sv
// Directed bench for keypad_event_ahb with a queue scoreboard of expected
// DATA words and a small timestamp model.
module tb_keypad_event_ahb;
    localparam int DEPTH = 8;

    logic        HCLK = 1'b0;
    logic        HRESET = 1'b1;
    logic [3:0]  key_interrupt = 4'h0;
    logic        key_irq;

    keypad_event_ahb_if bus_if ();

    keypad_event_ahb #(
        .FIFO_DEPTH (DEPTH),
        .TS_WIDTH   (16)
    ) dut (
        .HCLK          (HCLK),
        .HRESET        (HRESET),
        .bus           (bus_if),
        .key_interrupt (key_interrupt),
        .key_irq       (key_irq)
    );

    always #5 HCLK = ~HCLK;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q [$];
    logic        en_m = 1'b0;
    logic        irqen_m = 1'b0;
    logic        ovf_m = 1'b0;
    logic [15:0] ts_m = 16'h0;
    logic [31:0] rd_d;
    logic [31:0] rd_e;

    always @(posedge HCLK) begin
        if (HRESET) ts_m <= 16'h0;
        else if (en_m) ts_m <= ts_m + 16'd1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
        $display("check %-16s observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic logic [31:0] status_exp();
        return {25'd0, ovf_m, exp_q.size() == DEPTH, exp_q.size() == 0, 4'(exp_q.size())};
    endfunction

    task automatic tick();
        @(posedge HCLK);
        @(negedge HCLK);
    endtask

    task automatic bus_idle();
        bus_if.HSEL   = 1'b0;
        bus_if.HTRANS = 2'b00;
        bus_if.HWRITE = 1'b0;
    endtask

    // Model one key_interrupt sample at the coming edge (after any pop).
    task automatic model_event(input logic [3:0] mask, input bit flushed, input bit clr);
        bit set_ovf = 0;
        if (flushed) begin
            exp_q.delete();
        end else if (en_m && mask != 4'h0) begin
            if (exp_q.size() < DEPTH) exp_q.push_back({ts_m, 12'h000, mask});
            else set_ovf = 1;
        end
        if (set_ovf) ovf_m = 1'b1;
        else if (clr) ovf_m = 1'b0;
    endtask

    task automatic pulse(input logic [3:0] mask);
        key_interrupt = mask;
        model_event(mask, 0, 0);
        tick();
        key_interrupt = 4'h0;
    endtask

    task automatic ahb_read(input logic [3:0] addr, input logic [3:0] dp_mask,
                            output logic [31:0] data, output logic [31:0] exp_data);
        bus_if.HSEL   = 1'b1;
        bus_if.HTRANS = 2'b10;
        bus_if.HADDR  = addr;
        bus_if.HWRITE = 1'b0;
        tick();
        bus_idle();
        data = bus_if.HRDATA;
        exp_data = 32'h0;
        if (addr[3:2] == 2'd0 && exp_q.size() > 0) exp_data = exp_q.pop_front();
        key_interrupt = dp_mask;
        model_event(dp_mask, 0, 0);
        tick();
        key_interrupt = 4'h0;
    endtask

    task automatic ahb_write(input logic [3:0] addr, input logic [31:0] data, input logic [3:0] dp_mask);
        bus_if.HSEL   = 1'b1;
        bus_if.HTRANS = 2'b10;
        bus_if.HADDR  = addr;
        bus_if.HWRITE = 1'b1;
        tick();
        bus_idle();
        bus_if.HWDATA = data;
        key_interrupt = dp_mask;
        model_event(dp_mask, (addr == 4'hC) && data[0], (addr == 4'hC) && data[1]);
        tick();
        key_interrupt = 4'h0;
        if (addr == 4'h8) begin
            en_m    = data[0];
            irqen_m = data[1];
        end
    endtask

    task automatic check_reg(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        logic [31:0] e;
        ahb_read(addr, 4'h0, d, e);
        check(tag, d, exp);
    endtask

    task automatic check_data(input string tag, input logic [3:0] dp_mask);
        logic [31:0] d;
        logic [31:0] e;
        ahb_read(4'h0, dp_mask, d, e);
        check(tag, d, e);
    endtask

    task automatic do_reset();
        HRESET = 1'b1;
        tick();
        HRESET = 1'b0;
        exp_q.delete();
        en_m = 1'b0;
        irqen_m = 1'b0;
        ovf_m = 1'b0;
    endtask

    initial begin
        bus_idle();
        bus_if.HADDR  = 4'h0;
        bus_if.HSIZE  = 3'b010;
        bus_if.HWDATA = 32'h0;
        bus_if.HREADY = 1'b1;
        @(negedge HCLK);
        HRESET = 1'b1;
        repeat (3) tick();
        HRESET = 1'b0;

        // Reset state
        check("rst_irq", {31'd0, key_irq}, 32'h0);
        check("rst_readyout", {31'd0, bus_if.HREADYOUT}, 32'h1);
        check("rst_resp", {31'd0, bus_if.HRESP}, 32'h0);
        check("rst_hrdata", bus_if.HRDATA, 32'h0);
        check_reg("rst_status", 4'h4, 32'h10);
        check_reg("rst_ctrl", 4'h8, 32'h0);
        check_reg("rst_data", 4'h0, 32'h0);
        check_reg("rst_cmd", 4'hC, 32'h0);

        // Single event captured at ts=5
        ahb_write(4'h8, 32'h3, 4'h0);
        repeat (5) tick();
        pulse(4'b0101);
        check("evt_irq", {31'd0, key_irq}, 32'h1);
        check_reg("evt_status", 4'h4, 32'h01);
        ahb_read(4'h0, 4'h0, rd_d, rd_e);
        check("evt_data", rd_d, 32'h0005_0005);
        check("evt_data_sb", rd_d, rd_e);
        check_reg("evt_status2", 4'h4, 32'h10);
        check("evt_irq_clr", {31'd0, key_irq}, 32'h0);

        // Nine events: eight stored plus overflow
        for (int i = 0; i < 9; i++) pulse(4'(1 << (i % 4)));
        check_reg("ovf_status", 4'h4, 32'h68);
        for (int i = 0; i < 9; i++) check_data("ovf_drain", 4'h0);
        check_reg("ovf_sticky", 4'h4, 32'h50);
        ahb_write(4'hC, 32'h2, 4'h0);
        check_reg("ovf_cleared", 4'h4, 32'h10);

        // Full FIFO: pop and push in the same cycle
        for (int i = 0; i < DEPTH; i++) pulse(4'(i + 1));
        check_reg("full_status", 4'h4, 32'h28);
        check_data("full_rd_push", 4'b1000);
        check_reg("full_status2", 4'h4, 32'h28);
        for (int i = 0; i < DEPTH; i++) check_data("full_drain", 4'h0);
        check_reg("full_empty", 4'h4, 32'h10);

        // Empty FIFO: pop suppressed, push kept
        check_data("empty_rd_push", 4'b0010);
        check_reg("empty_push_st", 4'h4, status_exp());
        check_reg("empty_push_st1", 4'h4, 32'h01);
        check_data("empty_push_dat", 4'h0);

        // CLR_OVF coinciding with an overflowing event
        for (int i = 0; i < DEPTH; i++) pulse(4'b0100);
        ahb_write(4'hC, 32'h2, 4'b0001);
        check_reg("clr_vs_set", 4'h4, 32'h68);
        ahb_write(4'hC, 32'h3, 4'h0);
        check_reg("flush_clr", 4'h4, 32'h10);

        // EN=0: events ignored, timestamp frozen
        ahb_write(4'h8, 32'h0, 4'h0);
        pulse(4'b1111);
        check_reg("dis_status", 4'h4, 32'h10);
        repeat (10) tick();
        ahb_write(4'h8, 32'h1, 4'h0);
        check_reg("ctrl_rd", 4'h8, 32'h1);
        repeat (3) tick();
        pulse(4'b0001);
        check_data("frozen_ts", 4'h0);

        // FLUSH with a simultaneous event on three entries
        for (int i = 0; i < 3; i++) pulse(4'b0011);
        check_reg("three_status", 4'h4, 32'h03);
        check("irq_masked", {31'd0, key_irq}, 32'h0);
        ahb_write(4'hC, 32'h1, 4'b0100);
        check_reg("flush_push", 4'h4, 32'h10);

        // Timestamp wrap from a fresh reset
        do_reset();
        ahb_write(4'h8, 32'h1, 4'h0);
        repeat (32'h10002) tick();
        pulse(4'b0110);
        ahb_read(4'h0, 4'h0, rd_d, rd_e);
        check("ts_wrap", rd_d, 32'h0002_0006);

        // Reset during a DATA read data phase
        pulse(4'b1001);
        bus_if.HSEL   = 1'b1;
        bus_if.HTRANS = 2'b10;
        bus_if.HADDR  = 4'h0;
        bus_if.HWRITE = 1'b0;
        tick();
        bus_idle();
        do_reset();
        check("mid_rst_hrdata", bus_if.HRDATA, 32'h0);
        check("mid_rst_irq", {31'd0, key_irq}, 32'h0);
        check_reg("mid_rst_status", 4'h4, 32'h10);
        check_reg("mid_rst_ctrl", 4'h8, 32'h0);
        ahb_write(4'h8, 32'h1, 4'h0);
        pulse(4'b0001);
        ahb_read(4'h0, 4'h0, rd_d, rd_e);
        check("ts_restart", rd_d, 32'h0000_0001);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
